conv_anchor_gen_2d: RTL and testbench
=====================================

# conv_anchor_gen_2d

`ConvAnchorGen_2D` generates the 2D convolution window anchor coordinates. An anchor is the top-left input-map position of one kernel window, including the padding offset. The block scans the output feature map in raster order: width is the inner loop, height the outer loop. It sits at the front of the convolution datapath and drives the address generators that fetch each receptive field.

## Interface
Parameters:
- `IN_HEIGHT`, default 8: input feature-map height in pixels.
- `IN_WIDTH`, default 8: input feature-map width in pixels.
- `KERNEL_SIZE`, default 3: square kernel edge length.
- `STRIDE`, default 1: window step in both dimensions, must be ≥1.
- `PADDING`, default 1: zero-padding on each border; anchors can therefore be negative.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: synchronous, active-high reset. The port name is kept for codebase compatibility; 1 = reset.
- `enable`  in  1: work enable. 1 = run. 0 = clear the scan state to the first anchor.
- `pause`  in  1: 1 = freeze the scan and hold all state; only acts while `enable`=1.
- `anchor_height`  out  32: signed two's-complement row of the current anchor.
- `anchor_width`  out  32: signed two's-complement column of the current anchor.
- `anchor_valid`  out  1: current anchor is consumed at the next edge.
- `frame_last`  out  1: current anchor is the last of the frame and `anchor_valid`=1.

## Operation
- Output map size, using integer division:
  - OUT_H = (IN_HEIGHT + 2·PADDING − KERNEL_SIZE)/STRIDE + 1
  - OUT_W = (IN_WIDTH + 2·PADDING − KERNEL_SIZE)/STRIDE + 1
- Anchor sets:
  - Height: h ∈ {−PADDING + i·STRIDE}, i = 0..OUT_H−1.
  - Width: w ∈ {−PADDING + j·STRIDE}, j = 0..OUT_W−1.
- Internal state: two signed 32-bit registers `h_reg` and `w_reg`, plus index counters or comparisons against the last values H_LAST and W_LAST. H_LAST and W_LAST are computed at elaboration.
- Outputs `anchor_height` = `h_reg` and `anchor_width` = `w_reg`. They are driven directly from the registers, with no combinational arithmetic on the output path.
- `anchor_valid` = `enable` & ~`pause` (combinational).
- `frame_last` = `anchor_valid` & (h_reg == H_LAST) & (w_reg == W_LAST).
- States: IDLE when `enable`=0, RUN when `enable`=1 and `pause`=0, HOLD when `enable`=1 and `pause`=1. The state is implied by the inputs; no separate state register is required.
- Update rules at each rising edge, in priority order:
  1. Reset: `h_reg` = `w_reg` = −PADDING.
  2. `enable`=0: `h_reg` = `w_reg` = −PADDING.
  3. `pause`=1: hold both registers.
  4. Otherwise, if `w_reg` ≠ W_LAST: `w_reg` += STRIDE.
  5. Otherwise, if `h_reg` ≠ H_LAST: `w_reg` = −PADDING, `h_reg` += STRIDE.
  6. Otherwise (frame end): wrap both registers to −PADDING and continue scanning the next frame with no idle cycle.
- Arithmetic: 32-bit signed. All parameter values fit comfortably, so there is no overflow handling.

## Timing
- Reset value of the outputs: `anchor_height` = `anchor_width` = −PADDING (0xFFFFFFFF for the defaults). `anchor_valid` = `enable` & ~`pause`, and `frame_last` is 0.
- Each anchor is presented for exactly one cycle in RUN.
- The first anchor (−PADDING, −PADDING) appears in the first cycle `enable` is high. The second anchor appears one edge later.
- A full frame takes OUT_H·OUT_W RUN cycles; that is 64 cycles for the defaults.
- `pause` inserts hold cycles: outputs stay unchanged, `anchor_valid`=0, and the anchor resumes on the next RUN edge without being skipped or duplicated.
- `enable` dropping mid-frame clears the state at the next edge. When `enable` rises again, the scan restarts at (−PADDING, −PADDING).
- Reset mid-operation behaves identically to `enable`=0 and overrides both `enable` and `pause`.
- `pause` high while `enable`=0 has no effect; the state stays cleared.

## Test plan
- Reset, then `enable`=1, defaults: the first 9 anchors (h,w) are (−1,−1), (−1,0) … (−1,6), (0,−1); 64 distinct anchors per frame, ending at (6,6) with `frame_last`=1.
- Run for 130 RUN cycles: cycle 64 shows (−1,−1) again (wrap), and `frame_last` pulses exactly at cycles 63 and 127.
- At anchor (2,3), hold `pause`=1 for 5 cycles: the outputs stay at (2,3) with `anchor_valid`=0, then the sequence continues with (2,4).
- At anchor (4,0), drop `enable` for 2 cycles: the outputs return to (−1,−1), and after re-enable the sequence restarts at (−1,−1).
- Parameters IN=8, K=3, S=2, P=1: h and w each step through {−1,1,3,5}, giving 16 anchors per frame with the last at (5,5).
- Parameters P=0, K=3, S=1, IN=5: anchors run from (0,0) to (2,2), 9 per frame, and the reset value of the outputs is 0.

Source files
------------

// File: rtl/conv_anchor_gen_2d_if.sv
// Control/anchor bundle between the scan controller and
// the receptive-field address generators.
interface conv_anchor_gen_2d_if;
  logic               enable;
  logic               pause;
  logic signed [31:0] anchor_height;
  logic signed [31:0] anchor_width;
  logic               anchor_valid;
  logic               frame_last;

  modport master (
    output enable,
    output pause,
    input  anchor_height,
    input  anchor_width,
    input  anchor_valid,
    input  frame_last
  );

  modport slave (
    input  enable,
    input  pause,
    output anchor_height,
    output anchor_width,
    output anchor_valid,
    output frame_last
  );
endinterface

// File: rtl/conv_anchor_gen_2d.sv
// Raster-order generator of 2D convolution window anchors
// (top-left input position of each kernel window, padding included).
module conv_anchor_gen_2d #(
  parameter int IN_HEIGHT   = 8,
  parameter int IN_WIDTH    = 8,
  parameter int KERNEL_SIZE = 3,
  parameter int STRIDE      = 1,
  parameter int PADDING     = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  conv_anchor_gen_2d_if.slave bus
);

  localparam int OUT_H =
    (IN_HEIGHT + 2*PADDING - KERNEL_SIZE) / STRIDE + 1;
  localparam int OUT_W =
    (IN_WIDTH + 2*PADDING - KERNEL_SIZE) / STRIDE + 1;

  localparam int H_LAST_I = -PADDING + (OUT_H - 1) * STRIDE;
  localparam int W_LAST_I = -PADDING + (OUT_W - 1) * STRIDE;

  localparam logic signed [31:0] H_LAST = 32'(H_LAST_I);
  localparam logic signed [31:0] W_LAST = 32'(W_LAST_I);
  localparam logic signed [31:0] A_INIT = 32'(-PADDING);
  localparam logic signed [31:0] STEP   = 32'(STRIDE);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD
  } mode_t;

  mode_t w_mode;

  logic signed [31:0] r_h;
  logic signed [31:0] r_w;
  logic signed [31:0] w_h_nxt;
  logic signed [31:0] w_w_nxt;
  logic               w_h_last;
  logic               w_w_last;
  logic               w_valid;

  assign w_h_last = (r_h == H_LAST);
  assign w_w_last = (r_w == W_LAST);

  // Mode is a pure function of the inputs; no state register needed.
  always_comb begin
    w_mode = IDLE;
    if (bus.enable) begin
      if (bus.pause) w_mode = HOLD;
      else           w_mode = RUN;
    end
  end

  always_comb begin
    w_h_nxt = r_h;
    w_w_nxt = r_w;
    unique case (w_mode)
      IDLE: begin
        w_h_nxt = A_INIT;
        w_w_nxt = A_INIT;
      end
      HOLD: begin
        w_h_nxt = r_h;
        w_w_nxt = r_w;
      end
      RUN: begin
        if (!w_w_last) begin
          w_w_nxt = r_w + STEP;
        end else if (!w_h_last) begin
          w_w_nxt = A_INIT;
          w_h_nxt = r_h + STEP;
        end else begin
          // Frame end wraps straight into the next frame.
          w_w_nxt = A_INIT;
          w_h_nxt = A_INIT;
        end
      end
      default: begin
        w_h_nxt = A_INIT;
        w_w_nxt = A_INIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_h <= A_INIT;
      r_w <= A_INIT;
    end else begin
      r_h <= w_h_nxt;
      r_w <= w_w_nxt;
    end
  end

  assign w_valid = bus.enable & ~bus.pause;

  assign bus.anchor_height = r_h;
  assign bus.anchor_width  = r_w;
  assign bus.anchor_valid  = w_valid;
  assign bus.frame_last    = w_valid & w_h_last & w_w_last;

endmodule

// File: tb/tb_conv_anchor_gen_2d.sv
// Scoreboard bench for three anchor generator configurations:
// defaults, stride 2, and no-padding 5x5.
module tb_conv_anchor_gen_2d;

  typedef struct {
    int                 d;
    logic signed [31:0] h;
    logic signed [31:0] w;
    logic               v;
    logic               l;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [2:0] en_r;
  logic [2:0] pa_r;

  int checks = 0;
  int errors = 0;
  int tcyc   = 0;

  int P [3]  = '{1, 1, 0};
  int S [3]  = '{1, 2, 1};
  int OH [3] = '{8, 4, 3};
  int OW [3] = '{8, 4, 3};

  int mi [3] = '{0, 0, 0};
  int mj [3] = '{0, 0, 0};
  int fl_cnt [3] = '{0, 0, 0};
  int fl_pos [$];

  exp_t sb [$];

  logic signed [31:0] oh [3];
  logic signed [31:0] ow [3];
  logic               ov [3];
  logic               ol [3];

  conv_anchor_gen_2d_if if0 ();
  conv_anchor_gen_2d_if if1 ();
  conv_anchor_gen_2d_if if2 ();

  conv_anchor_gen_2d u_d0 (
    .clk   (clk),
    .rst_n (rst),
    .bus   (if0.slave)
  );

  conv_anchor_gen_2d #(
    .IN_HEIGHT   (8),
    .IN_WIDTH    (8),
    .KERNEL_SIZE (3),
    .STRIDE      (2),
    .PADDING     (1)
  ) u_d1 (
    .clk   (clk),
    .rst_n (rst),
    .bus   (if1.slave)
  );

  conv_anchor_gen_2d #(
    .IN_HEIGHT   (5),
    .IN_WIDTH    (5),
    .KERNEL_SIZE (3),
    .STRIDE      (1),
    .PADDING     (0)
  ) u_d2 (
    .clk   (clk),
    .rst_n (rst),
    .bus   (if2.slave)
  );

  assign if0.enable = en_r[0];
  assign if1.enable = en_r[1];
  assign if2.enable = en_r[2];
  assign if0.pause  = pa_r[0];
  assign if1.pause  = pa_r[1];
  assign if2.pause  = pa_r[2];

  assign oh[0] = if0.anchor_height;
  assign oh[1] = if1.anchor_height;
  assign oh[2] = if2.anchor_height;
  assign ow[0] = if0.anchor_width;
  assign ow[1] = if1.anchor_width;
  assign ow[2] = if2.anchor_width;
  assign ov[0] = if0.anchor_valid;
  assign ov[1] = if1.anchor_valid;
  assign ov[2] = if2.anchor_valid;
  assign ol[0] = if0.frame_last;
  assign ol[1] = if1.frame_last;
  assign ol[2] = if2.frame_last;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cycle(input bit r,
                       input bit [2:0] e,
                       input bit [2:0] p);
    exp_t x;
    rst  = r;
    en_r = e;
    pa_r = p;
    for (int d = 0; d < 3; d++) begin
      x.d = d;
      x.h = 32'(-P[d] + mi[d] * S[d]);
      x.w = 32'(-P[d] + mj[d] * S[d]);
      x.v = e[d] & ~p[d];
      x.l = x.v && (mi[d] == OH[d] - 1)
                && (mj[d] == OW[d] - 1);
      sb.push_back(x);
    end
    #1;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      checks++;
      if ({oh[x.d], ow[x.d], ov[x.d], ol[x.d]} !==
          {x.h, x.w, x.v, x.l}) begin
        errors++;
        $display("FAIL anchor d%0d cyc%0d: got (%0d,%0d) v%b l%b exp (%0d,%0d) v%b l%b",
                 x.d, tcyc, oh[x.d], ow[x.d], ov[x.d], ol[x.d],
                 x.h, x.w, x.v, x.l);
      end
      if (ol[x.d] === 1'b1) begin
        fl_cnt[x.d]++;
        if (x.d == 0) fl_pos.push_back(tcyc);
      end
    end
    @(posedge clk);
    for (int d = 0; d < 3; d++) begin
      if (r || !e[d]) begin
        mi[d] = 0;
        mj[d] = 0;
      end else if (!p[d]) begin
        if (mj[d] != OW[d] - 1) begin
          mj[d]++;
        end else if (mi[d] != OH[d] - 1) begin
          mj[d] = 0;
          mi[d]++;
        end else begin
          mi[d] = 0;
          mj[d] = 0;
        end
      end
    end
    tcyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    cycle(1'b1, 3'b000, 3'b000);
    tcyc = 0;
    for (int d = 0; d < 3; d++) fl_cnt[d] = 0;
    fl_pos.delete();
  endtask

  task automatic test_reset();
    cycle(1'b1, 3'b111, 3'b101);
    cycle(1'b1, 3'b011, 3'b000);
    cycle(1'b1, 3'b000, 3'b111);
  endtask

  task automatic test_frame_wrap();
    do_reset();
    for (int k = 0; k < 130; k++) cycle(1'b0, 3'b001, 3'b000);
    checks++;
    if (fl_pos.size() != 2 || fl_pos[0] != 63 || fl_pos[1] != 127) begin
      errors++;
      $display("FAIL frame_last_pulses: got count %0d exp 2 at 63,127",
               fl_pos.size());
      foreach (fl_pos[k]) $display("  pulse at %0d", fl_pos[k]);
    end
  endtask

  task automatic test_pause();
    do_reset();
    for (int k = 0; k < 28; k++) cycle(1'b0, 3'b001, 3'b000);
    for (int k = 0; k < 5; k++)  cycle(1'b0, 3'b001, 3'b001);
    for (int k = 0; k < 4; k++)  cycle(1'b0, 3'b001, 3'b000);
  endtask

  task automatic test_enable_drop();
    do_reset();
    for (int k = 0; k < 41; k++) cycle(1'b0, 3'b001, 3'b000);
    cycle(1'b0, 3'b000, 3'b000);
    cycle(1'b0, 3'b000, 3'b000);
    for (int k = 0; k < 4; k++) cycle(1'b0, 3'b001, 3'b000);
  endtask

  task automatic test_pause_idle();
    for (int k = 0; k < 3; k++) cycle(1'b0, 3'b000, 3'b111);
    for (int k = 0; k < 3; k++) cycle(1'b0, 3'b111, 3'b000);
  endtask

  task automatic test_mid_reset();
    for (int k = 0; k < 10; k++) cycle(1'b0, 3'b111, 3'b000);
    cycle(1'b1, 3'b111, 3'b010);
    cycle(1'b1, 3'b111, 3'b000);
    for (int k = 0; k < 3; k++) cycle(1'b0, 3'b111, 3'b000);
  endtask

  task automatic test_stride2();
    do_reset();
    for (int k = 0; k < 34; k++) cycle(1'b0, 3'b010, 3'b000);
    checks++;
    if (fl_cnt[1] != 2) begin
      errors++;
      $display("FAIL stride2_frames: got %0d frame_last exp 2",
               fl_cnt[1]);
    end
  endtask

  task automatic test_no_pad();
    do_reset();
    for (int k = 0; k < 20; k++) cycle(1'b0, 3'b100, 3'b000);
    checks++;
    if (fl_cnt[2] != 2) begin
      errors++;
      $display("FAIL nopad_frames: got %0d frame_last exp 2",
               fl_cnt[2]);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int k = 0; k < 70; k++) begin
      cycle(1'b0, 3'b111, 3'($urandom_range(0, 7)));
    end
  endtask

  initial begin
    rst  = 1'b1;
    en_r = 3'b000;
    pa_r = 3'b000;
    @(posedge clk);
    @(negedge clk);
    test_reset();
    test_frame_wrap();
    test_pause();
    test_enable_drop();
    test_pause_idle();
    test_mid_reset();
    test_stride2();
    test_no_pad();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
